pipelined_controller: RTL and testbench
=======================================

Name: pipelined_controller

Overview:
- Registered successor to the combinational decode controller; sits at the ID/EXE boundary.
- Decodes the opcode into a control word and registers it into the EXE stage.
- Inserts bubbles on hazard or flush, sequences multi-cycle MUL with a front-end stall, and counts illegal opcodes.

Parameters:
- OP_CODE_LEN, 6: opcode width; OP_* encodings from defines.v.
- EXE_CMD_LEN, 4: ALU command width; EXE_* encodings from defines.v.
- MUL_CYCLES, 4: EXE-stage cycles a MUL occupies; legal range 2..16.
- ILL_CNT_W, 8: width of the illegal-opcode counter.

Ports:
- clk  in  1  system clock; single clock domain, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opCode  in  OP_CODE_LEN  opcode of the instruction in ID.
- valid_in  in  1  ID holds a real instruction.
- hazard_detected  in  1  load-use hazard; insert bubble.
- flush  in  1  taken branch/jump in EXE; kill the ID instruction.
- EXE_CMD  out  EXE_CMD_LEN  registered ALU command.
- Branch_command  out  2  registered COND_* code.
- branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN, Is_Comp, MOV_EN, Is_Mul, is_jump  out  1 each  registered control flags.
- mul_stall  out  1  freeze PC and IF/ID while MUL is in EXE.
- mul_done  out  1  one-cycle pulse on the final MUL cycle.
- illegal_op  out  1  one-cycle pulse: undefined opcode accepted.
- illegal_cnt  out  ILL_CNT_W  saturating illegal-opcode count.

Behaviour:
- Reset: every output is 0 (illegal_cnt = 0); FSM = IDLE; pending_flush = 0.
- Latency: control word appears 1 cycle after opCode is presented.
- Decode table; unlisted flags are 0:
  - ADD/SUB/AND/SLL: matching EXE_*, WB_EN.
  - MUL: EXE_MUL, WB_EN, Is_Mul.
  - COMP: EXE_SUB, WB_EN, Is_Comp.
  - ADDI: EXE_ADD, WB_EN, Is_Imm.
  - MOV: EXE_NO_OPERATION, Is_Imm, MOV_EN.
  - LD: EXE_ADD, WB_EN, Is_Imm, ST_or_BNE, MEM_R_EN.
  - ST: EXE_ADD, Is_Imm, ST_or_BNE, MEM_W_EN.
  - BNE: EXE_NO_OPERATION, Is_Imm, COND_BNE, branchEn, ST_or_BNE.
  - JMP: EXE_NO_OPERATION, Is_Imm, COND_JUMP, branchEn, is_jump.
  - Any other opcode: all-zero word, plus an illegal_op pulse.
- IDLE, per-cycle priority:
  1. flush or !valid_in: load all-zero bubble.
  2. hazard_detected: load bubble. The hazard bubble zeroes the whole word, not only EXE_CMD/WB_EN/MEM_W_EN.
  3. Otherwise load the decoded word.
- Illegal opcodes are counted only when accepted under priority 3.
- Accepting MUL: Is_Mul=1; go to MUL_BUSY; counter = MUL_CYCLES-1; mul_stall=1 from the next cycle.
- MUL_BUSY:
  - Control register holds its value; opCode, hazard_detected and valid_in are ignored.
  - Counter decrements each cycle.
  - When counter = 1: mul_done=1 that cycle.
  - Next cycle: return to IDLE with mul_stall=0; the register updates with the normal IDLE priority.
- mul_stall timing: high for exactly MUL_CYCLES-1 consecutive cycles per MUL.
- flush during MUL_BUSY: sets pending_flush; the held MUL is not killed. On the IDLE-return cycle, pending_flush forces a bubble and then clears.
- Back-to-back MUL: the second MUL is accepted on the IDLE-return cycle and restarts the sequence with no gap cycle.
- illegal_cnt: increments by 1 per accepted illegal opcode; saturates at all-ones (no wrap).
- rst while in MUL_BUSY: same cycle takes effect; FSM → IDLE, mul_stall=0, word cleared, pending_flush cleared.

Optional Feature:
- Macro: CTRL_MULTICYCLE_MUL_EN.
- Defined: MUL sequencing exactly as above.
- Undefined:
  - MUL is single-cycle like ADD, with Is_Mul still set.
  - No MUL_BUSY state or counter is built.
  - mul_stall and mul_done are tied to 0; flush is always applied immediately.

Test Plan:
- Reset: rst=1 for 2 cycles with ADD on opCode → all outputs 0 and illegal_cnt=0; first post-reset edge loads WB_EN=1, EXE_CMD=EXE_ADD.
- LD then ST, hazard_detected=1 on the ST cycle → cycle 1: WB_EN=MEM_R_EN=ST_or_BNE=Is_Imm=1; cycle 2: all-zero word.
- MUL with MUL_CYCLES=4 (macro defined) → Is_Mul held 4 cycles; mul_stall=1 for 3 cycles; mul_done pulses in the 3rd stalled cycle; ADD on the following cycle loads normally.
- MUL, then flush=1 during the 2nd busy cycle → MUL word still held the full 4 cycles; next word is a bubble although opCode=ADD with valid_in=1.
- 300 consecutive illegal opcodes (ILL_CNT_W=8) → 300 illegal_op pulses; illegal_cnt reaches 255 and stays there.
- rst asserted in the 2nd MUL_BUSY cycle → the next cycle has mul_stall=0 and Is_Mul=0, with no mul_done pulse.

Source files
------------

// File: rtl/pipelined_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_controller
// Purpose  : ID/EXE control-word register with bubble insertion, multi-cycle
//            MUL sequencing (CTRL_MULTICYCLE_MUL_EN) and illegal-opcode count.
// Revision : 1.0  initial release
// ============================================================================
module pipelined_controller #(
  parameter int OP_CODE_LEN = 6,
  parameter int EXE_CMD_LEN = 4,
  parameter int MUL_CYCLES  = 4,
  parameter int ILL_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_CODE_LEN-1:0] opCode,
  input  logic                   valid_in,
  input  logic                   hazard_detected,
  input  logic                   flush,
  output logic [EXE_CMD_LEN-1:0] EXE_CMD,
  output logic [1:0]             Branch_command,
  output logic                   branchEn,
  output logic                   Is_Imm,
  output logic                   ST_or_BNE,
  output logic                   WB_EN,
  output logic                   MEM_R_EN,
  output logic                   MEM_W_EN,
  output logic                   Is_Comp,
  output logic                   MOV_EN,
  output logic                   Is_Mul,
  output logic                   is_jump,
  output logic                   mul_stall,
  output logic                   mul_done,
  output logic                   illegal_op,
  output logic [ILL_CNT_W-1:0]   illegal_cnt
);

  localparam logic [OP_CODE_LEN-1:0] OP_ADD  = OP_CODE_LEN'(1);
  localparam logic [OP_CODE_LEN-1:0] OP_SUB  = OP_CODE_LEN'(3);
  localparam logic [OP_CODE_LEN-1:0] OP_AND  = OP_CODE_LEN'(5);
  localparam logic [OP_CODE_LEN-1:0] OP_SLL  = OP_CODE_LEN'(10);
  localparam logic [OP_CODE_LEN-1:0] OP_MUL  = OP_CODE_LEN'(13);
  localparam logic [OP_CODE_LEN-1:0] OP_COMP = OP_CODE_LEN'(14);
  localparam logic [OP_CODE_LEN-1:0] OP_MOV  = OP_CODE_LEN'(15);
  localparam logic [OP_CODE_LEN-1:0] OP_ADDI = OP_CODE_LEN'(32);
  localparam logic [OP_CODE_LEN-1:0] OP_LD   = OP_CODE_LEN'(36);
  localparam logic [OP_CODE_LEN-1:0] OP_ST   = OP_CODE_LEN'(37);
  localparam logic [OP_CODE_LEN-1:0] OP_BNE  = OP_CODE_LEN'(41);
  localparam logic [OP_CODE_LEN-1:0] OP_JMP  = OP_CODE_LEN'(42);

  localparam logic [EXE_CMD_LEN-1:0] EXE_ADD          = EXE_CMD_LEN'(1);
  localparam logic [EXE_CMD_LEN-1:0] EXE_SUB          = EXE_CMD_LEN'(2);
  localparam logic [EXE_CMD_LEN-1:0] EXE_AND          = EXE_CMD_LEN'(3);
  localparam logic [EXE_CMD_LEN-1:0] EXE_SLL          = EXE_CMD_LEN'(4);
  localparam logic [EXE_CMD_LEN-1:0] EXE_MUL          = EXE_CMD_LEN'(5);
  localparam logic [EXE_CMD_LEN-1:0] EXE_NO_OPERATION = EXE_CMD_LEN'(15);

  localparam logic [1:0] COND_BNE  = 2'd2;
  localparam logic [1:0] COND_JUMP = 2'd3;

  if (MUL_CYCLES < 2 || MUL_CYCLES > 16) begin : g_mul_cycles_check
    $error("pipelined_controller: MUL_CYCLES must be within 2..16");
  end

  typedef struct packed {
    logic [EXE_CMD_LEN-1:0] exe_cmd;
    logic [1:0]             br_cmd;
    logic                   branch_en;
    logic                   is_imm;
    logic                   st_or_bne;
    logic                   wb_en;
    logic                   mem_r_en;
    logic                   mem_w_en;
    logic                   is_comp;
    logic                   mov_en;
    logic                   is_mul;
    logic                   is_jump;
  } ctrl_word_t;

  ctrl_word_t             dec_word;
  logic                   dec_illegal;
  ctrl_word_t             word_q, word_d;
  logic                   illegal_op_q, illegal_op_d;
  logic [ILL_CNT_W-1:0]   illegal_cnt_q, illegal_cnt_d;
  logic                   busy;
  logic                   pending_flush;
  logic                   accept;

  always_comb begin
    dec_word    = '0;
    dec_illegal = 1'b0;
    case (opCode)
      OP_ADD:  begin dec_word.exe_cmd = EXE_ADD; dec_word.wb_en = 1'b1; end
      OP_SUB:  begin dec_word.exe_cmd = EXE_SUB; dec_word.wb_en = 1'b1; end
      OP_AND:  begin dec_word.exe_cmd = EXE_AND; dec_word.wb_en = 1'b1; end
      OP_SLL:  begin dec_word.exe_cmd = EXE_SLL; dec_word.wb_en = 1'b1; end
      OP_MUL: begin
        dec_word.exe_cmd = EXE_MUL;
        dec_word.wb_en   = 1'b1;
        dec_word.is_mul  = 1'b1;
      end
      OP_COMP: begin
        dec_word.exe_cmd = EXE_SUB;
        dec_word.wb_en   = 1'b1;
        dec_word.is_comp = 1'b1;
      end
      OP_ADDI: begin
        dec_word.exe_cmd = EXE_ADD;
        dec_word.wb_en   = 1'b1;
        dec_word.is_imm  = 1'b1;
      end
      OP_MOV: begin
        dec_word.exe_cmd = EXE_NO_OPERATION;
        dec_word.is_imm  = 1'b1;
        dec_word.mov_en  = 1'b1;
      end
      OP_LD: begin
        dec_word.exe_cmd   = EXE_ADD;
        dec_word.wb_en     = 1'b1;
        dec_word.is_imm    = 1'b1;
        dec_word.st_or_bne = 1'b1;
        dec_word.mem_r_en  = 1'b1;
      end
      OP_ST: begin
        dec_word.exe_cmd   = EXE_ADD;
        dec_word.is_imm    = 1'b1;
        dec_word.st_or_bne = 1'b1;
        dec_word.mem_w_en  = 1'b1;
      end
      OP_BNE: begin
        dec_word.exe_cmd   = EXE_NO_OPERATION;
        dec_word.is_imm    = 1'b1;
        dec_word.br_cmd    = COND_BNE;
        dec_word.branch_en = 1'b1;
        dec_word.st_or_bne = 1'b1;
      end
      OP_JMP: begin
        dec_word.exe_cmd   = EXE_NO_OPERATION;
        dec_word.is_imm    = 1'b1;
        dec_word.br_cmd    = COND_JUMP;
        dec_word.branch_en = 1'b1;
        dec_word.is_jump   = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Only a decoded word that survives every bubble source is "accepted".
  assign accept = !busy && valid_in && !flush && !hazard_detected && !pending_flush;

`ifdef CTRL_MULTICYCLE_MUL_EN
  localparam int               CNT_W    = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic             pending_flush_q, pending_flush_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mul_cnt_q       <= '0;
      pending_flush_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      mul_cnt_q       <= mul_cnt_d;
      pending_flush_q <= pending_flush_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    mul_cnt_d       = mul_cnt_q;
    pending_flush_d = pending_flush_q;
    case (state_q)
      ST_IDLE: begin
        pending_flush_d = 1'b0;
        if (accept && dec_word.is_mul) begin
          state_d   = ST_MUL_BUSY;
          mul_cnt_d = MUL_LOAD;
        end
      end
      ST_MUL_BUSY: begin
        // A branch resolving under the MUL must still kill the next ID slot.
        if (flush) pending_flush_d = 1'b1;
        mul_cnt_d = mul_cnt_q - CNT_W'(1);
        if (mul_cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy          = (state_q == ST_MUL_BUSY);
  assign pending_flush = pending_flush_q;
  assign mul_stall     = busy;
  assign mul_done      = busy && (mul_cnt_q == CNT_W'(1));
`else
  assign busy          = 1'b0;
  assign pending_flush = 1'b0;
  assign mul_stall     = 1'b0;
  assign mul_done      = 1'b0;
`endif

  always_comb begin
    word_d        = word_q;
    illegal_op_d  = 1'b0;
    illegal_cnt_d = illegal_cnt_q;
    if (!busy) begin
      word_d = '0;
      if (accept) begin
        word_d       = dec_word;
        illegal_op_d = dec_illegal;
        if (dec_illegal && (illegal_cnt_q != '1)) begin
          illegal_cnt_d = illegal_cnt_q + ILL_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q        <= '0;
      illegal_op_q  <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      word_q        <= word_d;
      illegal_op_q  <= illegal_op_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign EXE_CMD        = word_q.exe_cmd;
  assign Branch_command = word_q.br_cmd;
  assign branchEn       = word_q.branch_en;
  assign Is_Imm         = word_q.is_imm;
  assign ST_or_BNE      = word_q.st_or_bne;
  assign WB_EN          = word_q.wb_en;
  assign MEM_R_EN       = word_q.mem_r_en;
  assign MEM_W_EN       = word_q.mem_w_en;
  assign Is_Comp        = word_q.is_comp;
  assign MOV_EN         = word_q.mov_en;
  assign Is_Mul         = word_q.is_mul;
  assign is_jump        = word_q.is_jump;
  assign illegal_op     = illegal_op_q;
  assign illegal_cnt    = illegal_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_controller
// Purpose  : Self-checking bench for pipelined_controller against a cycle
//            reference model; follows CTRL_MULTICYCLE_MUL_EN if defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_controller;

  localparam int MUL_CYCLES = 4;
  localparam int ILL_W      = 8;
`ifdef CTRL_MULTICYCLE_MUL_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  localparam logic [5:0] OP_ADD = 6'd1,  OP_SUB = 6'd3,  OP_AND = 6'd5,  OP_SLL = 6'd10;
  localparam logic [5:0] OP_MUL = 6'd13, OP_COMP = 6'd14, OP_MOV = 6'd15, OP_ADDI = 6'd32;
  localparam logic [5:0] OP_LD  = 6'd36, OP_ST = 6'd37,  OP_BNE = 6'd41, OP_JMP = 6'd42;
  localparam logic [5:0] OP_BAD = 6'd2;

  logic       clk = 1'b0;
  logic       rst, valid_in, hazard_detected, flush;
  logic [5:0] opCode;
  logic [3:0] EXE_CMD;
  logic [1:0] Branch_command;
  logic       branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN;
  logic       Is_Comp, MOV_EN, Is_Mul, is_jump, mul_stall, mul_done, illegal_op;
  logic [7:0] illegal_cnt;

  always #5 clk = ~clk;

  pipelined_controller #(
    .OP_CODE_LEN(6), .EXE_CMD_LEN(4), .MUL_CYCLES(MUL_CYCLES), .ILL_CNT_W(ILL_W)
  ) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .valid_in(valid_in),
    .hazard_detected(hazard_detected), .flush(flush),
    .EXE_CMD(EXE_CMD), .Branch_command(Branch_command), .branchEn(branchEn),
    .Is_Imm(Is_Imm), .ST_or_BNE(ST_or_BNE), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .Is_Comp(Is_Comp), .MOV_EN(MOV_EN), .Is_Mul(Is_Mul),
    .is_jump(is_jump), .mul_stall(mul_stall), .mul_done(mul_done),
    .illegal_op(illegal_op), .illegal_cnt(illegal_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Word layout: {exe[3:0], cond[1:0], br_en, imm, st_bne, wb, mr, mw, comp, mov, mul, jmp}
  function automatic logic [16:0] ref_decode(input logic [5:0] op);
    case (op)
      OP_ADD:  return {1'b1, 4'd1,  2'd0, 10'b0001000000};
      OP_SUB:  return {1'b1, 4'd2,  2'd0, 10'b0001000000};
      OP_AND:  return {1'b1, 4'd3,  2'd0, 10'b0001000000};
      OP_SLL:  return {1'b1, 4'd4,  2'd0, 10'b0001000000};
      OP_MUL:  return {1'b1, 4'd5,  2'd0, 10'b0001000010};
      OP_COMP: return {1'b1, 4'd2,  2'd0, 10'b0001001000};
      OP_ADDI: return {1'b1, 4'd1,  2'd0, 10'b0101000000};
      OP_MOV:  return {1'b1, 4'd15, 2'd0, 10'b0100000100};
      OP_LD:   return {1'b1, 4'd1,  2'd0, 10'b0111100000};
      OP_ST:   return {1'b1, 4'd1,  2'd0, 10'b0110010000};
      OP_BNE:  return {1'b1, 4'd15, 2'd2, 10'b1110000000};
      OP_JMP:  return {1'b1, 4'd15, 2'd3, 10'b1100000001};
      default: return 17'd0;
    endcase
  endfunction

  logic [15:0] m_word = '0;
  bit          m_ill  = 1'b0;
  int          m_cnt  = 0;
  int          m_left = 0;   // EXE cycles the current MUL still freezes the front end
  bit          m_pend = 1'b0;
  int          ill_pulses = 0;

  task automatic model_update(input logic [5:0] op, input bit v, h, f, r);
    logic [16:0] d;
    d = ref_decode(op);
    if (r) begin
      m_word = '0; m_ill = 1'b0; m_cnt = 0; m_left = 0; m_pend = 1'b0;
    end else if (m_left > 0) begin
      m_ill = 1'b0;
      if (f) m_pend = 1'b1;
      m_left--;
    end else begin
      if (f || !v || h || m_pend) begin
        m_word = '0; m_ill = 1'b0;
      end else begin
        m_word = d[15:0];
        m_ill  = !d[16];
        if (!d[16] && m_cnt < (1 << ILL_W) - 1) m_cnt++;
        if (MC && op == OP_MUL) m_left = MUL_CYCLES - 1;
      end
      m_pend = 1'b0;
    end
  endtask

  function automatic logic [15:0] dut_word();
    return {EXE_CMD, Branch_command, branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN,
            MEM_W_EN, Is_Comp, MOV_EN, Is_Mul, is_jump};
  endfunction

  task automatic step(input logic [5:0] op, input bit v, h, f, r);
    opCode = op; valid_in = v; hazard_detected = h; flush = f; rst = r;
    @(posedge clk);
    model_update(op, v, h, f, r);
    @(negedge clk);
    if (illegal_op) ill_pulses++;
    check("cycle", {5'd0, dut_word(), mul_stall, mul_done, illegal_op, illegal_cnt},
          {5'd0, m_word, m_left > 0, m_left == 1, m_ill, 8'(m_cnt)});
  endtask

  logic [5:0] legal_ops [12] = '{OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_MUL, OP_COMP,
                                 OP_MOV, OP_ADDI, OP_LD, OP_ST, OP_BNE, OP_JMP};

  initial begin
    int held, stalls, done_at;
    logic [16:0] add_ref;
    add_ref = ref_decode(OP_ADD);

    // Reset with ADD on the bus, then the first post-reset edge
    step(OP_ADD, 1, 0, 0, 1);
    step(OP_ADD, 1, 0, 0, 1);
    check("rst_word", {16'd0, dut_word()}, 32'd0);
    check("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
    check("rst_stall", {30'd0, mul_stall, mul_done}, 32'd0);
    step(OP_ADD, 1, 0, 0, 0);
    check("add_exe", {28'd0, EXE_CMD}, 32'd1);
    check("add_wb", {31'd0, WB_EN}, 32'd1);

    // LD then ST under a hazard
    step(OP_LD, 1, 0, 0, 0);
    check("ld_flags", {28'd0, WB_EN, MEM_R_EN, ST_or_BNE, Is_Imm}, 32'hF);
    step(OP_ST, 1, 1, 0, 0);
    check("haz_bubble", {16'd0, dut_word()}, 32'd0);

    // MUL sequence followed by ADD
    held = 0; stalls = 0; done_at = 0;
    for (int i = 1; i <= 5; i++) begin
      step(i == 1 ? OP_MUL : OP_ADD, 1, 0, 0, 0);
      held += int'(Is_Mul);
      stalls += int'(mul_stall);
      if (mul_done) done_at = i;
    end
    check("mul_held", held, MC ? 32'd4 : 32'd1);
    check("mul_stall_cnt", stalls, MC ? 32'd3 : 32'd0);
    check("mul_done_cyc", done_at, MC ? 32'd3 : 32'd0);
    check("mul_then_add", {16'd0, dut_word()}, {16'd0, add_ref[15:0]});

    // Flush in the second busy cycle
    held = 0;
    for (int i = 1; i <= 5; i++) begin
      step(i == 1 ? OP_MUL : OP_ADD, 1, 0, i == 3, 0);
      held += int'(Is_Mul);
    end
    check("flush_held", held, MC ? 32'd4 : 32'd1);
    check("flush_bubble", {16'd0, dut_word()}, MC ? 32'd0 : {16'd0, add_ref[15:0]});

    // Saturating illegal counter
    step(OP_ADD, 1, 0, 0, 1);
    ill_pulses = 0;
    for (int i = 0; i < 300; i++) step(OP_BAD, 1, 0, 0, 0);
    check("ill_pulses", ill_pulses, 32'd300);
    check("ill_sat", {24'd0, illegal_cnt}, 32'd255);
    step(OP_BAD, 1, 0, 0, 0);
    check("ill_hold", {24'd0, illegal_cnt}, 32'd255);

    // Reset in the second busy cycle
    step(OP_MUL, 1, 0, 0, 0);
    step(OP_ADD, 1, 0, 0, 0);
    step(OP_ADD, 1, 0, 0, 1);
    check("rst_busy", {29'd0, mul_stall, Is_Mul, mul_done}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 11)] : 6'($urandom);
      step(op, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
